pipe_issue_arbiter: RTL and testbench

- Front-end scheduler for the 4-stage 8-bit pipelined_processor (IF, ID, EX, WB).
- Shares the single instruction input between NUM_REQ requesters using round-robin arbitration.
- The processor has no valid bit, so the arbiter injects a NOP when no instruction is issued.
- Tags every in-flight slot so each result returns with the originating requester ID; a halt/drain FSM quiesces the pipe.

---
 rtl/pipe_issue_arbiter.sv | 146 ++++++++++++++
 tb/tb_pipe_issue_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_issue_arbiter.sv
// rtl/pipe_issue_arbiter.sv - round-robin issue arbiter with result tagging and halt/drain for a 4-stage pipe
module pipe_issue_arbiter #(
   parameter int         NUM_REQ   = 2,
   parameter int         ID_W      = 2,
   parameter logic [7:0] NOP_INSTR = 8'hC0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_instr,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic                 halt_req,
   output logic [7:0]           pipe_instr,
   input  logic [7:0]           pipe_res,
   output logic                 rsp_valid,
   output logic [ID_W-1:0]      rsp_id,
   output logic [7:0]           rsp_data,
   output logic                 rsp_err,
   output logic [2:0]           inflight,
   output logic                 halted
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ID_W-1:0]   r_ptr;
   logic [3:0]        r_tag_v;
   logic [3:0]        r_tag_err;
   logic [ID_W-1:0]   r_tag_id [0:3];

   logic              w_arb_en;
   logic              w_fire;
   logic [ID_W-1:0]   w_grant_idx;
   logic [7:0]        w_grant_instr;
   logic              w_grant_err;

   // Requester index visited at step k of the search, starting just after the pointer
   function automatic int rr_idx(input logic [ID_W-1:0] ptr, input int k);
      int s;
      s = int'(ptr) + k;
      if (s >= NUM_REQ) begin
         s = s - NUM_REQ;
      end
      return s;
   endfunction

   assign w_arb_en = (r_state == ST_RUN);

   // Round-robin search: first valid requester after the last granted one wins
   always_comb begin
      w_fire        = 1'b0;
      w_grant_idx   = '0;
      w_grant_instr = NOP_INSTR;
      req_ready     = '0;
      if (w_arb_en) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!w_fire && (i == rr_idx(r_ptr, k)) && req_valid[i]) begin
                  w_fire        = 1'b1;
                  w_grant_idx   = ID_W'(i);
                  w_grant_instr = req_instr[8*i +: 8];
                  req_ready[i]  = 1'b1;
               end
            end
         end
      end
   end

   assign w_grant_err = w_fire && (w_grant_instr[7:6] == 2'b11);
   assign pipe_instr  = w_grant_instr;

   // Pointer remembers the last granted requester so it drops to lowest priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= ID_W'(NUM_REQ - 1);
      end else if (w_fire) begin
         r_ptr <= w_grant_idx;
      end
   end

   // Tag shift register tracks each issued slot alongside the processor stages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag_v   <= '0;
         r_tag_err <= '0;
         for (int k = 0; k < 4; k++) begin
            r_tag_id[k] <= '0;
         end
      end else begin
         r_tag_v   <= {r_tag_v[2:0], w_fire};
         r_tag_err <= {r_tag_err[2:0], w_grant_err};
         r_tag_id[0] <= w_fire ? w_grant_idx : '0;
         for (int k = 1; k < 4; k++) begin
            r_tag_id[k] <= r_tag_id[k-1];
         end
      end
   end

   assign rsp_valid = r_tag_v[3];
   assign rsp_id    = r_tag_id[3];
   assign rsp_err   = r_tag_err[3];
   assign rsp_data  = pipe_res;
   assign inflight  = {2'b00, r_tag_v[0]} + {2'b00, r_tag_v[1]}
                    + {2'b00, r_tag_v[2]} + {2'b00, r_tag_v[3]};
   assign halted    = (r_state == ST_HALTED);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: stop issuing on halt, wait for the pipe to empty, resume on release
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (halt_req) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (inflight == 3'd0) begin
               w_state_nxt = ST_HALTED;
            end
         end
         ST_HALTED: begin
            if (!halt_req) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// tb/tb_pipe_issue_arbiter.sv - directed self-checking bench for pipe_issue_arbiter
module tb_pipe_issue_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [15:0] req_instr;
   logic [1:0]  req_ready;
   logic        halt_req;
   logic [7:0]  pipe_instr;
   logic [7:0]  pipe_res;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic [2:0]  inflight;
   logic        halted;

   int n_checks;
   int n_pass;
   int n_rsp;
   int found;

   logic [7:0] p_if;
   logic [7:0] p_id;
   logic [7:0] p_ex;

   pipe_issue_arbiter #(
      .NUM_REQ   (2),
      .ID_W      (2),
      .NOP_INSTR (8'hC0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_instr  (req_instr),
      .req_ready  (req_ready),
      .halt_req   (halt_req),
      .pipe_instr (pipe_instr),
      .pipe_res   (pipe_res),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .inflight   (inflight),
      .halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Processor stand-in: op 00 ADD, 01 SUB, 10 LOAD b, 11 writes 0
   function automatic logic [7:0] alu(input logic [7:0] ins);
      case (ins[7:6])
         2'b00:   return {5'b0, ins[5:3]} + {5'b0, ins[2:0]};
         2'b01:   return {5'b0, ins[5:3]} - {5'b0, ins[2:0]};
         2'b10:   return {5'b0, ins[2:0]};
         default: return 8'h00;
      endcase
   endfunction

   // Four-stage processor: instr sampled on edge 1, result visible after edge 4
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         p_if     <= 8'hC0;
         p_id     <= 8'hC0;
         p_ex     <= 8'hC0;
         pipe_res <= 8'h00;
      end else begin
         p_if     <= pipe_instr;
         p_id     <= p_if;
         p_ex     <= p_id;
         pipe_res <= alu(p_ex);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 2'b00;
      halt_req  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      req_valid = 2'b00;
      req_instr = 16'hC0C0;
      halt_req  = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_pipe_instr", pipe_instr, 8'hC0);
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_inflight", inflight, 3'd0);
      chk("rst_halted", halted, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Idle: no responses
      n_rsp = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rsp_valid) n_rsp++;
         next_cyc();
      end
      chk("idle_rsp_count", n_rsp, 0);

      // Single ADD 3+2 from req0
      req_instr[7:0] = 8'h1A;
      req_valid      = 2'b01;
      @(negedge clk);
      chk("add_ready", req_ready, 2'b01);
      chk("add_pipe_instr", pipe_instr, 8'h1A);
      next_cyc();
      req_valid = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("add_inflight", inflight, 3'd1);
         chk("add_rsp_valid", rsp_valid, (k == 4));
         if (k == 4) begin
            chk("add_rsp_id", rsp_id, 2'd0);
            chk("add_rsp_data", rsp_data, 8'h05);
            chk("add_rsp_err", rsp_err, 1'b0);
         end
         next_cyc();
      end
      @(negedge clk);
      chk("add_inflight_done", inflight, 3'd0);
      chk("add_rsp_done", rsp_valid, 1'b0);
      next_cyc();

      // Round-robin: req0 SUB 5-3, req1 LOAD 7, both valid for 6 cycles
      do_reset();
      req_instr = {8'h87, 8'h6B};
      req_valid = 2'b11;
      for (int c = 0; c < 10; c++) begin
         if (c == 6) req_valid = 2'b00;
         @(negedge clk);
         if (c < 6) chk("rr_grant", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
         if (c >= 4) begin
            chk("rr_rsp_valid", rsp_valid, 1'b1);
            chk("rr_rsp_id", rsp_id, (c - 4) % 2);
            chk("rr_rsp_data", rsp_data, ((c - 4) % 2 == 1) ? 8'h07 : 8'h02);
         end
         next_cyc();
      end
      @(negedge clk);
      chk("rr_rsp_done", rsp_valid, 1'b0);
      next_cyc();

      // Wrap and error: SUB 3-5 on req0, then 8'hFF on req1
      for (int c = 0; c < 6; c++) begin
         if (c == 0) begin
            req_instr[7:0] = 8'h5D;
            req_valid      = 2'b01;
         end else if (c == 1) begin
            req_instr[15:8] = 8'hFF;
            req_valid       = 2'b10;
         end else begin
            req_valid = 2'b00;
         end
         @(negedge clk);
         if (c == 0) chk("wrap_ready", req_ready, 2'b01);
         if (c == 1) begin
            chk("err_ready", req_ready, 2'b10);
            chk("err_pipe_instr", pipe_instr, 8'hFF);
         end
         if (c == 4) begin
            chk("wrap_rsp_valid", rsp_valid, 1'b1);
            chk("wrap_rsp_data", rsp_data, 8'hFE);
            chk("wrap_rsp_err", rsp_err, 1'b0);
         end
         if (c == 5) begin
            chk("err_rsp_valid", rsp_valid, 1'b1);
            chk("err_rsp_id", rsp_id, 2'd1);
            chk("err_rsp_data", rsp_data, 8'h00);
            chk("err_rsp_err", rsp_err, 1'b1);
         end
         next_cyc();
      end

      // Halt/drain: three issues, halt raised on the third handshake edge
      req_instr[7:0] = 8'h1A;
      req_valid      = 2'b01;
      for (int c = 0; c < 8; c++) begin
         if (c == 2) halt_req = 1'b1;
         @(negedge clk);
         if (c < 3) begin
            chk("halt_issue_ready", req_ready, 2'b01);
         end else begin
            chk("halt_blocked_ready", req_ready, 2'b00);
            chk("halt_nop", pipe_instr, 8'hC0);
            case (c)
               3: chk("drain_inflight3", inflight, 3'd3);
               4: chk("drain_inflight4", inflight, 3'd3);
               5: chk("drain_inflight5", inflight, 3'd2);
               6: chk("drain_inflight6", inflight, 3'd1);
               default: chk("drain_inflight7", inflight, 3'd0);
            endcase
            chk("drain_rsp_valid", rsp_valid, (c >= 4) && (c <= 6));
            if (c >= 4 && c <= 6) chk("drain_rsp_data", rsp_data, 8'h05);
         end
         if (c == 6) chk("drain_not_halted", halted, 1'b0);
         next_cyc();
      end
      found = 0;
      for (int w = 0; w < 4; w++) begin
         @(negedge clk);
         if (halted) begin
            found = 1;
            break;
         end
         next_cyc();
      end
      chk("halted_reached", found, 1);
      chk("halted_inflight", inflight, 3'd0);
      next_cyc();
      halt_req = 1'b0;
      @(negedge clk);
      chk("halted_hold", halted, 1'b1);
      chk("halted_ready", req_ready, 2'b00);
      next_cyc();
      @(negedge clk);
      chk("resume_halted", halted, 1'b0);
      chk("resume_ready", req_ready, 2'b01);
      chk("resume_pipe_instr", pipe_instr, 8'h1A);
      next_cyc();
      req_valid = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("resume_rsp_valid", rsp_valid, (k == 4));
         if (k == 4) chk("resume_rsp_data", rsp_data, 8'h05);
         next_cyc();
      end

      // Reset mid-flight: two issues dropped by reset
      req_instr[7:0] = 8'h6B;
      req_valid      = 2'b01;
      next_cyc();
      next_cyc();
      req_valid = 2'b00;
      @(negedge clk);
      chk("mid_inflight_before", inflight, 3'd2);
      #1 rst = 1'b1;
      #1;
      chk("mid_inflight_reset", inflight, 3'd0);
      chk("mid_rsp_reset", rsp_valid, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      n_rsp = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rsp_valid) n_rsp++;
         next_cyc();
      end
      chk("mid_no_rsp", n_rsp, 0);
      req_instr[7:0] = 8'h87;
      req_valid      = 2'b01;
      @(negedge clk);
      chk("post_rst_ready", req_ready, 2'b01);
      next_cyc();
      req_valid = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 4) begin
            chk("post_rst_rsp_valid", rsp_valid, 1'b1);
            chk("post_rst_rsp_id", rsp_id, 2'd0);
            chk("post_rst_rsp_data", rsp_data, 8'h07);
         end
         next_cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
